// File: rtl/button_debouncer_if.sv
// Button debouncer signal bundle: raw pin toward the debouncer, clean level, strobes and glitch count back.
interface button_debouncer_if;
    logic       button_raw;
    logic       button_clean;
    logic       rise_pulse;
    logic       fall_pulse;
    logic [7:0] glitch_count;

    modport master (
        output button_raw,
        input  button_clean,
        input  rise_pulse,
        input  fall_pulse,
        input  glitch_count
    );

    modport slave (
        input  button_raw,
        output button_clean,
        output rise_pulse,
        output fall_pulse,
        output glitch_count
    );
endinterface

// File: rtl/button_debouncer.sv
// Synchronises a bouncing button pin and accepts a new level only after DEBOUNCE_CYCLES stable samples.
// Emits one-cycle rise/fall strobes and a saturating count of aborted transitions.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    button_debouncer_if.slave  bus
);

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned GLIT_W  = 8;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GLIT_W-1:0] GLIT_MAX = {GLIT_W{1'b1}};

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } state_e;

    state_e              state_q;
    logic                sync1_q;
    logic                sync2_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                clean_q;
    logic                rise_q;
    logic                fall_q;
    logic [GLIT_W-1:0]   glitch_q;
    logic [GLIT_W-1:0]   glitch_d;

    // Saturating increment used on every aborted wait
    assign glitch_d = (glitch_q == GLIT_MAX) ? glitch_q : glitch_q + GLIT_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            state_q  <= STABLE_LOW;
            cnt_q    <= '0;
            clean_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= '0;
        end else begin
            sync1_q <= bus.button_raw;
            sync2_q <= sync1_q;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            case (state_q)
                STABLE_LOW: begin
                    if (sync2_q) begin
                        state_q <= WAIT_HIGH;
                        cnt_q   <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!sync2_q) begin
                        state_q  <= STABLE_LOW;
                        glitch_q <= glitch_d;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= STABLE_HIGH;
                        clean_q <= 1'b1;
                        rise_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                STABLE_HIGH: begin
                    if (!sync2_q) begin
                        state_q <= WAIT_LOW;
                        cnt_q   <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (sync2_q) begin
                        state_q  <= STABLE_HIGH;
                        glitch_q <= glitch_d;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= STABLE_LOW;
                        clean_q <= 1'b0;
                        fall_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= STABLE_LOW;
            endcase
        end
    end

    assign bus.button_clean = clean_q;
    assign bus.rise_pulse   = rise_q;
    assign bus.fall_pulse   = fall_q;
    assign bus.glitch_count = glitch_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: two instances (DEBOUNCE_CYCLES 4 and 8) sharing clock and reset.
module tb_button_debouncer;

    logic clk;
    logic reset_n;
    int   tests_run;
    int   tests_failed;

    button_debouncer_if if4 ();
    button_debouncer_if if8 ();

    button_debouncer #(.DEBOUNCE_CYCLES(4)) u_dut4 (.clk(clk), .reset_n(reset_n), .bus(if4));
    button_debouncer #(.DEBOUNCE_CYCLES(8)) u_dut8 (.clk(clk), .reset_n(reset_n), .bus(if8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n        = 1'b0;
        if4.button_raw = 1'b1;
        if8.button_raw = 1'b1;
        repeat (3) tick();
        tests_run++;
        if ({if4.button_clean, if4.rise_pulse, if4.fall_pulse} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_outputs4 got %b expected 000", {if4.button_clean, if4.rise_pulse, if4.fall_pulse});
        end
        tests_run++;
        if (if4.glitch_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_glitch4 got %0d expected 0", if4.glitch_count);
        end
        tests_run++;
        if ({if8.button_clean, if8.rise_pulse, if8.fall_pulse, if8.glitch_count} !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs8 got %b expected 0", {if8.button_clean, if8.rise_pulse, if8.fall_pulse, if8.glitch_count});
        end
        if4.button_raw = 1'b0;
        if8.button_raw = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_press();
        if4.button_raw = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            tick();
            tests_run++;
            if ({if4.rise_pulse, if4.fall_pulse, if4.button_clean} !== {(e == 7), 1'b0, (e >= 7)}) begin
                tests_failed++;
                $display("FAIL press_edge%0d rise/fall/clean got %b expected %b", e,
                         {if4.rise_pulse, if4.fall_pulse, if4.button_clean}, {(e == 7), 1'b0, (e >= 7)});
            end
        end
    endtask

    task automatic test_release();
        if4.button_raw = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            tick();
            tests_run++;
            if ({if4.rise_pulse, if4.fall_pulse, if4.button_clean} !== {1'b0, (e == 7), (e < 7)}) begin
                tests_failed++;
                $display("FAIL release_edge%0d rise/fall/clean got %b expected %b", e,
                         {if4.rise_pulse, if4.fall_pulse, if4.button_clean}, {1'b0, (e == 7), (e < 7)});
            end
        end
    endtask

    task automatic test_bounce();
        logic [9:0] pat;
        pat = 10'b1111111011;  // bit 0 drives edge 1
        for (int e = 1; e <= 12; e++) begin
            if (e <= 10) if4.button_raw = pat[e-1];
            tick();
            tests_run++;
            if ({if4.rise_pulse, if4.button_clean, if4.glitch_count} !== {(e == 10), (e >= 10), ((e >= 5) ? 8'd1 : 8'd0)}) begin
                tests_failed++;
                $display("FAIL bounce_edge%0d rise/clean/glitch got %b/%b/%0d expected %b/%b/%0d", e,
                         if4.rise_pulse, if4.button_clean, if4.glitch_count, (e == 10), (e >= 10), (e >= 5) ? 1 : 0);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        if4.button_raw = 1'b0;
        repeat (10) tick();
        tests_run++;
        if ({if4.button_clean, if4.glitch_count} !== {1'b0, 8'd1}) begin
            tests_failed++;
            $display("FAIL pre_reset clean/glitch got %b/%0d expected 0/1", if4.button_clean, if4.glitch_count);
        end
        if4.button_raw = 1'b1;
        repeat (4) tick();
        #2;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if ({if4.button_clean, if4.rise_pulse, if4.fall_pulse, if4.glitch_count} !== 11'd0) begin
            tests_failed++;
            $display("FAIL async_reset clean/rise/fall/glitch got %b expected 0",
                     {if4.button_clean, if4.rise_pulse, if4.fall_pulse, if4.glitch_count});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if ({if4.rise_pulse, if4.button_clean} !== 2'b00) begin
                tests_failed++;
                $display("FAIL in_reset_cycle%0d rise/clean got %b expected 00", i, {if4.rise_pulse, if4.button_clean});
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            tests_run++;
            if ({if4.rise_pulse, if4.button_clean} !== {(e == 7), (e >= 7)}) begin
                tests_failed++;
                $display("FAIL post_reset_edge%0d rise/clean got %b expected %b", e,
                         {if4.rise_pulse, if4.button_clean}, {(e == 7), (e >= 7)});
            end
        end
    endtask

    task automatic test_saturation();
        logic saw_high;
        saw_high = 1'b0;
        for (int g = 0; g < 300; g++) begin
            if8.button_raw = 1'b1;
            tick();
            saw_high |= if8.button_clean | if8.rise_pulse;
            if8.button_raw = 1'b0;
            for (int i = 0; i < 3; i++) begin
                tick();
                saw_high |= if8.button_clean | if8.rise_pulse;
            end
            if (g == 9 || g == 254) begin
                tests_run++;
                if (if8.glitch_count !== ((g == 9) ? 8'd10 : 8'd255)) begin
                    tests_failed++;
                    $display("FAIL sat_after_%0d got %0d expected %0d", g + 1, if8.glitch_count, (g == 9) ? 10 : 255);
                end
            end
        end
        repeat (4) tick();
        tests_run++;
        if (if8.glitch_count !== 8'd255) begin
            tests_failed++;
            $display("FAIL sat_final got %0d expected 255", if8.glitch_count);
        end
        tests_run++;
        if (saw_high !== 1'b0) begin
            tests_failed++;
            $display("FAIL sat_clean_or_rise got %b expected 0", saw_high);
        end
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        reset_n        = 1'b0;
        if4.button_raw = 1'b0;
        if8.button_raw = 1'b0;
        test_reset();
        test_press();
        test_release();
        test_bounce();
        test_reset_mid_wait();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
